mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter for a single shared memory. It serves one access at a time
// to either the fetch port (read only) or the data port (read or write). The
// data port normally has priority. A starvation counter guarantees that the
// fetch port is served after STARVE_MAX consecutive data grants. A per-access
// timeout drops accesses that the memory never acknowledges. A sticky error
// flag records protocol problems.
//
// Parameters
//   TIMEOUT     cycles in BUSY without mem_ack before the access is dropped
//   STARVE_MAX  consecutive data grants tolerated while a fetch waits
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   if_req / if_addr    fetch request (held until if_done) and its address
//   if_rdata / if_done  fetch read data and one-cycle completion pulse
//   dm_req / dm_wr      data request (held until dm_done), 1 = write
//   dm_addr / dm_wdata  data address and write data
//   dm_rdata / dm_done  data read data and one-cycle completion pulse
//   mem_en / mem_wr     one-cycle access strobe and its write qualifier
//   mem_addr/mem_wdata  address and write data, stable for the whole access
//   mem_rdata/mem_ack   memory read data and completion strobe
//   if_stall/dm_stall   port request pending and not yet done
//   err                 sticky error flag, cleared only by rst
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int TIMEOUT    = 15,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        if_stall,
  output logic        dm_stall,
  output logic        err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t        state_q;
  logic          mem_en_q;
  logic          mem_wr_q;
  logic [15:0]   mem_addr_q;
  logic [15:0]   mem_wdata_q;
  logic [15:0]   if_rdata_q;
  logic [15:0]   dm_rdata_q;
  logic          if_done_q;
  logic          dm_done_q;
  logic          err_q;
  logic [SW-1:0] starve_q;
  logic [TW-1:0] tmo_q;
  // Shift register that masks mem_ack for the cycles right after reset, so a
  // late acknowledge of an access aborted by rst is not treated as an error.
  logic [1:0]    rst_hold_q;
  // Previous-cycle view of the data port, used to detect a waiting request
  // whose address or direction changes before it is granted.
  logic          dm_wait_q;
  logic          dm_wr_prev_q;
  logic [15:0]   dm_addr_prev_q;

  logic          err_d;
  logic [SW-1:0] starve_d;
  logic          busy;
  logic          if_ok;
  logic          dm_ok;
  logic          grant_if;
  logic          grant_dm;
  logic          ack_ok;
  logic          tmo_hit;
  logic          dm_changed;

  always_comb begin
    busy     = (state_q != IDLE);
    // A port whose done pulse is showing right now is not grantable, so a
    // request still held during its own done cycle is not served twice.
    if_ok    = if_req & ~if_done_q;
    dm_ok    = dm_req & ~dm_done_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state_q == IDLE) begin
      if (if_ok && ((starve_q == STARVE_LIM) || !dm_ok)) begin
        grant_if = 1'b1;
      end else if (dm_ok) begin
        grant_dm = 1'b1;
      end
    end

    // The acknowledge is only meaningful once the strobe cycle has passed.
    ack_ok     = busy & mem_ack & ~mem_en_q;
    tmo_hit    = busy & ~ack_ok & (tmo_q == TMO_LAST);
    dm_changed = dm_wait_q & dm_req &
                 ((dm_addr != dm_addr_prev_q) | (dm_wr != dm_wr_prev_q));

    err_d = err_q | tmo_hit | dm_changed | (mem_ack & mem_en_q) |
            (mem_ack & (state_q == IDLE) & ~(|rst_hold_q));

    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_dm && if_req && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      mem_en_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      if_rdata_q     <= '0;
      dm_rdata_q     <= '0;
      if_done_q      <= 1'b0;
      dm_done_q      <= 1'b0;
      err_q          <= 1'b0;
      starve_q       <= '0;
      tmo_q          <= '0;
      rst_hold_q     <= 2'b11;
      dm_wait_q      <= 1'b0;
      dm_wr_prev_q   <= 1'b0;
      dm_addr_prev_q <= '0;
    end else begin
      // Strobes and done pulses are single-cycle by default.
      mem_en_q       <= 1'b0;
      if_done_q      <= 1'b0;
      dm_done_q      <= 1'b0;
      err_q          <= err_d;
      starve_q       <= starve_d;
      rst_hold_q     <= {rst_hold_q[0], 1'b0};
      dm_wr_prev_q   <= dm_wr;
      dm_addr_prev_q <= dm_addr;
      // Waiting means requested, not completing, and not being served.
      dm_wait_q      <= dm_ok & ~grant_dm & (state_q != BUSY_DM);

      case (state_q)
        IDLE: begin
          if (grant_if) begin
            state_q     <= BUSY_IF;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            tmo_q       <= '0;
          end else if (grant_dm) begin
            state_q     <= BUSY_DM;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= dm_wr;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
            tmo_q       <= '0;
          end
        end

        BUSY_IF, BUSY_DM: begin
          if (ack_ok) begin
            state_q  <= IDLE;
            mem_wr_q <= 1'b0;
            if (state_q == BUSY_IF) begin
              if_rdata_q <= mem_rdata;
              if_done_q  <= 1'b1;
            end else begin
              // Writes complete without disturbing the last read data.
              if (!mem_wr_q) begin
                dm_rdata_q <= mem_rdata;
              end
              dm_done_q <= 1'b1;
            end
          end else if (tmo_hit) begin
            // Abandon the access silently; err_d already records it.
            state_q  <= IDLE;
            mem_wr_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign err       = err_q;
  assign if_stall  = if_req & ~if_done_q;
  assign dm_stall  = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_arbiter with default parameters (TIMEOUT=15,
// STARVE_MAX=3). Inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        if_stall;
  logic        dm_stall;
  logic        err;

  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int ifd_cnt = 0;
  int dmd_cnt = 0;
  int base_en, base_if, base_dm;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(15), .STARVE_MAX(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .dm_req   (dm_req),
    .dm_wr    (dm_wr),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_done  (dm_done),
    .mem_en   (mem_en),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .if_stall (if_stall),
    .dm_stall (dm_stall),
    .err      (err)
  );

  // Pulse counters; only read at falling edges where the counted signal is low.
  always @(negedge clk) begin
    if (mem_en === 1'b1)  en_cnt++;
    if (if_done === 1'b1) ifd_cnt++;
    if (dm_done === 1'b1) dmd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (mem_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_en"}, 32'(mem_en), 32'd1);
  endtask

  // Drive one acknowledge cycle; returns in the cycle where done should show.
  task automatic ack(input logic [15:0] rd);
    mem_rdata = rd;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_en"},    32'(mem_en),    32'd0);
    chk({tag, "_mem_wr"},    32'(mem_wr),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_if_rdata"},  32'(if_rdata),  32'd0);
    chk({tag, "_dm_rdata"},  32'(dm_rdata),  32'd0);
    chk({tag, "_if_done"},   32'(if_done),   32'd0);
    chk({tag, "_dm_done"},   32'(dm_done),   32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_wr = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    step(3);
    chk_reset_outputs("rst0");
    chk("rst0_if_stall", 32'(if_stall), 32'd0);
    chk("rst0_dm_stall", 32'(dm_stall), 32'd0);
    rst = 1'b0;
    step(3);

    // Single fetch, ack two cycles after the strobe.
    base_en = en_cnt; base_if = ifd_cnt;
    if_req = 1'b1; if_addr = 16'h0010;
    #1 chk("t1_if_stall", 32'(if_stall), 32'd1);
    wait_en("t1");
    chk("t1_addr", 32'(mem_addr), 32'h0010);
    chk("t1_wr", 32'(mem_wr), 32'd0);
    step(2);
    ack(16'hBEEF);
    chk("t1_done", 32'(if_done), 32'd1);
    chk("t1_rdata", 32'(if_rdata), 32'hBEEF);
    chk("t1_stall_at_done", 32'(if_stall), 32'd0);
    if_req = 1'b0;
    step(2);
    chk("t1_en_count", 32'(en_cnt - base_en), 32'd1);
    chk("t1_done_count", 32'(ifd_cnt - base_if), 32'd1);
    chk("t1_err", 32'(err), 32'd0);

    // Simultaneous fetch and data write: data first, then the fetch.
    if_req = 1'b1; if_addr = 16'h0044;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
    wait_en("t2dm");
    chk("t2dm_addr", 32'(mem_addr), 32'h0200);
    chk("t2dm_wr", 32'(mem_wr), 32'd1);
    chk("t2dm_wdata", 32'(mem_wdata), 32'h1234);
    step();
    ack(16'hDEAD);
    chk("t2dm_done", 32'(dm_done), 32'd1);
    chk("t2dm_rdata_kept", 32'(dm_rdata), 32'h0000);
    chk("t2_if_still_stalled", 32'(if_stall), 32'd1);
    dm_req = 1'b0; dm_wr = 1'b0;
    wait_en("t2if");
    chk("t2if_addr", 32'(mem_addr), 32'h0044);
    chk("t2if_wr", 32'(mem_wr), 32'd0);
    step();
    ack(16'h5A5A);
    chk("t2if_done", 32'(if_done), 32'd1);
    chk("t2if_rdata", 32'(if_rdata), 32'h5A5A);
    if_req = 1'b0;
    step();

    // Minimum latency data read: request, strobe, ack, done.
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0300;
    step();
    chk("t3_en", 32'(mem_en), 32'd1);
    chk("t3_addr", 32'(mem_addr), 32'h0300);
    step();
    chk("t3_en_off", 32'(mem_en), 32'd0);
    mem_rdata = 16'hC0DE; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t3_done", 32'(dm_done), 32'd1);
    chk("t3_rdata", 32'(dm_rdata), 32'hC0DE);
    dm_req = 1'b0;
    step();

    // Starvation: three data grants while a fetch is asserted, then fetch wins.
    for (int k = 0; k < 3; k++) begin
      if_req = 1'b1; if_addr = 16'h0100;
      dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0400 + 16'(k);
      step();
      chk($sformatf("t4_dm_grant%0d", k), 32'(mem_addr), 32'h0400 + k);
      if_req = 1'b0;
      step();
      ack(16'(k));
      chk($sformatf("t4_dm_done%0d", k), 32'(dm_done), 32'd1);
      dm_req = 1'b0;
      step();
    end
    if_req = 1'b1; if_addr = 16'h0100;
    dm_req = 1'b1; dm_addr = 16'h0403;
    step();
    chk("t4_if_wins", 32'(mem_addr), 32'h0100);
    chk("t4_if_wr", 32'(mem_wr), 32'd0);
    chk("t4_dm_stall", 32'(dm_stall), 32'd1);
    step();
    ack(16'h9999);
    chk("t4_if_done", 32'(if_done), 32'd1);
    chk("t4_if_rdata", 32'(if_rdata), 32'h9999);
    if_req = 1'b0;
    wait_en("t4dm");
    chk("t4dm_addr", 32'(mem_addr), 32'h0403);
    step();
    ack(16'h7777);
    chk("t4dm_done", 32'(dm_done), 32'd1);
    chk("t4dm_rdata", 32'(dm_rdata), 32'h7777);
    dm_req = 1'b0;
    step();
    if_req = 1'b1; dm_req = 1'b1; dm_addr = 16'h0404;
    step();
    chk("t4_starve_cleared", 32'(mem_addr), 32'h0404);
    if_req = 1'b0;
    step();
    ack(16'h0000);
    dm_req = 1'b0;
    step();
    chk("t4_err", 32'(err), 32'd0);

    // Timeout: no ack for 15 busy cycles.
    base_dm = dmd_cnt;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0500;
    wait_en("t5");
    step(14);
    chk("t5_err_pre", 32'(err), 32'd0);
    dm_req = 1'b0;
    step();
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_no_done_now", 32'(dm_done), 32'd0);
    step(2);
    chk("t5_no_done_count", 32'(dmd_cnt - base_dm), 32'd0);
    if_req = 1'b1; if_addr = 16'h0600;
    step();
    chk("t5_idle_grant", 32'(mem_en), 32'd1);
    chk("t5_addr", 32'(mem_addr), 32'h0600);
    step(2);
    ack(16'h1111);
    chk("t5_if_done", 32'(if_done), 32'd1);
    chk("t5_if_rdata", 32'(if_rdata), 32'h1111);
    chk("t5_err_sticky", 32'(err), 32'd1);
    if_req = 1'b0;
    step();

    // Reset clears err; ack just after reset is ignored; ack in IDLE flags err.
    rst = 1'b1;
    step(2);
    chk("t6_err_clr", 32'(err), 32'd0);
    rst = 1'b0;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t6_postrst_ack", 32'(err), 32'd0);
    step(2);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t6_idle_ack", 32'(err), 32'd1);
    rst = 1'b1;
    step();
    chk_reset_outputs("t6rst");
    step();
    rst = 1'b0;
    step(2);

    // Reset in the second BUSY_DM cycle aborts without a done pulse.
    base_dm = dmd_cnt;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0700; dm_wdata = 16'hAAAA;
    step();
    chk("t7_en", 32'(mem_en), 32'd1);
    step();
    rst = 1'b1; dm_req = 1'b0; dm_wr = 1'b0;
    step();
    chk("t7_en_off", 32'(mem_en), 32'd0);
    chk("t7_done_off", 32'(dm_done), 32'd0);
    chk("t7_addr_clr", 32'(mem_addr), 32'h0000);
    rst = 1'b0;
    step(3);
    chk("t7_no_done_count", 32'(dmd_cnt - base_dm), 32'd0);
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0800;
    wait_en("t7new");
    chk("t7new_addr", 32'(mem_addr), 32'h0800);
    step();
    ack(16'h4242);
    chk("t7new_done", 32'(dm_done), 32'd1);
    chk("t7new_rdata", 32'(dm_rdata), 32'h4242);
    dm_req = 1'b0;
    step();
    chk("t7_err", 32'(err), 32'd0);

    // Waiting data request changes address; latched fetch address holds.
    if_req = 1'b1; if_addr = 16'h0900;
    step();
    chk("t8_en", 32'(mem_en), 32'd1);
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0A00; if_addr = 16'h0F0F;
    step();
    chk("t8_addr_hold", 32'(mem_addr), 32'h0900);
    chk("t8_err_pre", 32'(err), 32'd0);
    dm_addr = 16'h0A02;
    step();
    chk("t8_err_addr_change", 32'(err), 32'd1);
    ack(16'h8888);
    chk("t8_if_done", 32'(if_done), 32'd1);
    chk("t8_if_rdata", 32'(if_rdata), 32'h8888);
    if_req = 1'b0;
    wait_en("t8dm");
    chk("t8dm_addr", 32'(mem_addr), 32'h0A02);
    step();
    ack(16'h3333);
    chk("t8dm_done", 32'(dm_done), 32'd1);
    chk("t8dm_rdata", 32'(dm_rdata), 32'h3333);
    dm_req = 1'b0;
    step();

    // Ack coincident with the strobe is rejected and flags err.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(3);
    if_req = 1'b1; if_addr = 16'h0B00;
    step();
    chk("t9_en", 32'(mem_en), 32'd1);
    mem_rdata = 16'hEEEE; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t9_err", 32'(err), 32'd1);
    chk("t9_no_done", 32'(if_done), 32'd0);
    ack(16'h1234);
    chk("t9_done", 32'(if_done), 32'd1);
    chk("t9_rdata", 32'(if_rdata), 32'h1234);
    if_req = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
